red_pitaya_relock: RTL
======================

// Module: red_pitaya_relock
// PURPOSE
//  Single-channel lock supervisor between PID output and red_pitaya_limit input.
//  - LOCKED: passes PID data through; watches limiter rail flags.
//  - Rails held too long: holds PID integrator, sweeps a triangle around the limiter range centre.
//  - Returns to LOCKED once a lock-indicator signal stays above threshold.
//  Instantiated once per channel; registers on the system bus like the other blocks.
// PARAMETERS
//  CNT_W   20  width of holdoff/settle/prescale counters and their config registers
//  RLC_W   16  width of relock event counter (saturating)
// PORTS
//  clk_i         in   1   ADC clock
//  rstn_i        in   1   reset, asynchronous, active-low
//  pid_dat_i     in   14  signed PID output
//  lock_sig_i    in   14  signed lock indicator (e.g. transmission ADC)
//  railed_i      in   2   limiter rail flags, bit0 lower, bit1 upper
//  center_i      in   14  signed limiter range centre
//  dat_o         out  14  signed data to limiter (registered)
//  pid_hold_o    out  1   1 = freeze/clear PID integrator
//  searching_o   out  1   1 = state SEARCH or ACQUIRE
//  sys_addr/sys_wdata in 32, sys_wen/sys_ren in 1, sys_rdata out 32, sys_err/sys_ack out 1
// BEHAVIOUR
//  Reset: dat_o=0, pid_hold_o=0, searching_o=0, sys_ack=0, sys_err=0, sys_rdata=0; state DISABLED; all counters 0.
//  Registers (sys_addr[19:0]), reset values in brackets:
//   0x00 ctrl[0] enable [0]            0x04 holdoff cycles [1000]
//   0x08 step (14b unsigned) [1]       0x0C prescale cycles per step [0 = every cycle]
//   0x10 amplitude (14b unsigned) [0x1000]  0x14 threshold (14b signed) [0]
//   0x18 settle cycles [1000]          0x1C status RO: [1:0] state, [31:16] relock count
//  Any write to 0x1C clears relock count. sys_ack = sys_wen|sys_ren one cycle later, every address.
//  Unmapped reads return 0. sys_err always 0.
//  States: DISABLED=0, LOCKED=1, SEARCH=2, ACQUIRE=3.
//  Priority each cycle: enable=0 -> DISABLED, overrides all transitions.
//  - DISABLED: dat_o<=pid_dat_i, hold=0; enable=1 -> LOCKED.
//  - LOCKED: dat_o<=pid_dat_i, hold=0.
//    rail_cnt increments while railed_i!=0 and clears when railed_i==0.
//    rail_cnt reaching holdoff -> SEARCH with off=0, dir=up, relock count +1 (saturates at max).
//  - SEARCH: hold=1, dat_o<=sat14(center_i+off).
//    off moves by step every prescale+1 cycles, clamps at +/-amplitude; dir flips on the clamp.
//    lock_sig_i>threshold -> ACQUIRE; settle_cnt=0, off frozen.
//  - ACQUIRE: dat_o<=sat14(center_i+off), hold=0 (PID re-engages).
//    lock_sig_i<=threshold -> back to SEARCH, sweep resumes from off.
//    settle_cnt reaching settle -> LOCKED, rail_cnt=0.
//  Arithmetic: off is signed 15b; center_i+off is computed in 16b, then saturated to [-8192,8191].
//  amplitude=0: off stays 0. step>amplitude: off bounces between +amp and -amp.
//  holdoff=0 behaves as 1 (one railed cycle triggers). settle=0 behaves as 1.
//  Config writes during SEARCH take effect on the next step, with no restart.
//  Latency: every path pid_dat_i/center_i -> dat_o is 1 cycle. State outputs are registered.
// STRUCTURE
//  Shared package: state encoding constants, register offsets, reset defaults.
//  Sub-module red_pitaya_relock_sweep: prescaler, off, dir.
//   Ports: clk_i, rstn_i, run_i, clr_i, step_i, amp_i, presc_i, off_o.
//  Top level holds FSM, rail/settle counters, output mux with saturation, bus decode.
// TESTING
//  1 enable=1, pid=100, railed=0 -> dat_o=100 one cycle later; state=1, hold=0.
//  2 holdoff=10, railed=2'b10 held 9 cycles then cleared, then held 10 cycles:
//    no SEARCH after the 9; SEARCH after the 10; hold=1; relock count=1.
//  3 SEARCH, center=0, step=100, amp=250, prescale=0:
//    dat_o sequence 100,200,250,150,50,-50,-150,-250,-150.
//  4 center=8000, off reaching +250 -> dat_o=8191 (saturated).
//  5 SEARCH, lock_sig=500 > threshold=400 -> ACQUIRE, off frozen; dip to 300 mid-settle -> SEARCH resumes.
//    Above threshold for settle=20 cycles -> LOCKED, dat_o=pid.
//  6 enable cleared in SEARCH -> DISABLED next cycle, hold=0.
//    rstn_i low mid-ACQUIRE -> all outputs 0 asynchronously.
//    Write 0x1C -> relock count 0; read of 0x40 returns 0 with ack.

Source files
------------

// File: rtl/red_pitaya_relock_pkg.sv
// Shared definitions for the relock supervisor: state encoding,
// register map offsets, reset defaults and the 14-bit saturator.
package red_pitaya_relock_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_SEARCH   = 2'd2,
    ST_ACQUIRE  = 2'd3
  } state_e;

  localparam logic [19:0] A_CTRL    = 20'h00;
  localparam logic [19:0] A_HOLDOFF = 20'h04;
  localparam logic [19:0] A_STEP    = 20'h08;
  localparam logic [19:0] A_PRESC   = 20'h0C;
  localparam logic [19:0] A_AMP     = 20'h10;
  localparam logic [19:0] A_THR     = 20'h14;
  localparam logic [19:0] A_SETTLE  = 20'h18;
  localparam logic [19:0] A_STATUS  = 20'h1C;

  localparam int unsigned HOLDOFF_RST = 1000;
  localparam int unsigned SETTLE_RST  = 1000;
  localparam logic [13:0] STEP_RST    = 14'd1;
  localparam logic [13:0] AMP_RST     = 14'h1000;
  localparam logic [13:0] THR_RST     = 14'd0;

  function automatic logic [13:0] sat14(
    input logic signed [15:0] x
  );
    if (x > 16'sd8191)
      return 14'h1FFF;
    else if (x < -16'sd8192)
      return 14'h2000;
    else
      return x[13:0];
  endfunction

endpackage

// File: rtl/red_pitaya_relock_sweep.sv
// Triangle sweep generator: prescaled stepping of a signed offset
// that bounces between +amp_i and -amp_i.
// Ports: run_i steps, clr_i zeroes offset/dir/prescaler,
// step_i/amp_i/presc_i config, off_o signed 15-bit offset.
module red_pitaya_relock_sweep
  import red_pitaya_relock_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              run_i,
  input  logic              clr_i,
  input  logic [13:0]       step_i,
  input  logic [13:0]       amp_i,
  input  logic [CNT_W-1:0]  presc_i,
  output logic [14:0]       off_o
);

  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic signed [14:0] off_q, off_d;
  logic               dn_q, dn_d;
  logic signed [16:0] off_x, step_x, amp_x;
  logic signed [16:0] up_s, dn_s;

  assign off_x  = {{2{off_q[14]}}, off_q};
  assign step_x = {3'b000, step_i};
  assign amp_x  = {3'b000, amp_i};
  assign up_s   = off_x + step_x;
  assign dn_s   = off_x - step_x;
  assign off_o  = off_q;

  // Clamp on reaching the rail and flip direction there, so an
  // oversized step simply bounces between the two rails.
  always_comb begin
    pcnt_d = pcnt_q;
    off_d  = off_q;
    dn_d   = dn_q;
    if (clr_i) begin
      pcnt_d = '0;
      off_d  = '0;
      dn_d   = 1'b0;
    end else if (run_i) begin
      if (pcnt_q >= presc_i) begin
        pcnt_d = '0;
        if (!dn_q) begin
          if (up_s >= amp_x) begin
            off_d = amp_x[14:0];
            dn_d  = 1'b1;
          end else begin
            off_d = up_s[14:0];
          end
        end else begin
          if (dn_s <= -amp_x) begin
            off_d = dn_s[14:0];
            off_d = 15'(-amp_x);
            dn_d  = 1'b0;
          end else begin
            off_d = dn_s[14:0];
          end
        end
      end else begin
        pcnt_d = pcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pcnt_q <= '0;
      off_q  <= '0;
      dn_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      off_q  <= off_d;
      dn_q   <= dn_d;
    end
  end

endmodule

// File: rtl/red_pitaya_relock.sv
// Single-channel lock supervisor between PID and limiter.
// Ports: pid/lock/rail/centre inputs, dat_o/pid_hold_o/searching_o,
// sys_* register bus (ack one cycle after wen|ren, err always 0).
module red_pitaya_relock
  import red_pitaya_relock_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int RLC_W = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [13:0] pid_dat_i,
  input  logic [13:0] lock_sig_i,
  input  logic [1:0]  railed_i,
  input  logic [13:0] center_i,
  output logic [13:0] dat_o,
  output logic        pid_hold_o,
  output logic        searching_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  state_e             state_q, state_d;
  logic               en_q;
  logic [CNT_W-1:0]   holdoff_q, presc_q, settle_q;
  logic [CNT_W-1:0]   rail_q, rail_d, scnt_q, scnt_d;
  logic [13:0]        step_q, amp_q;
  logic signed [13:0] thr_q;
  logic [RLC_W-1:0]   rlc_q, rlc_d;
  logic [CNT_W:0]     rail_nx, scnt_nx, hold_lim, set_lim;
  logic [CNT_W:0]     one_x;
  logic [14:0]        off;
  logic signed [15:0] sum;
  logic [13:0]        dat_q;
  logic               hold_q, srch_q, ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [19:0]        addr;
  logic               lock_hi, wr_status, sw_run, sw_clr;
  logic               unused_ok;

  assign addr      = sys_addr[19:0];
  assign unused_ok = ^{sys_addr[31:20], sys_wdata[31:20]};
  assign lock_hi   = $signed(lock_sig_i) > thr_q;
  assign wr_status = sys_wen && (addr == A_STATUS);
  assign one_x     = {{CNT_W{1'b0}}, 1'b1};
  assign rail_nx   = {1'b0, rail_q} + one_x;
  assign scnt_nx   = {1'b0, scnt_q} + one_x;
  // A zero limit behaves as one.
  assign hold_lim  = {1'b0, holdoff_q} |
                     {{CNT_W{1'b0}}, holdoff_q == '0};
  assign set_lim   = {1'b0, settle_q} |
                     {{CNT_W{1'b0}}, settle_q == '0};

  // Offset is cleared while not hunting, frozen in ACQUIRE.
  assign sw_clr = (state_q == ST_LOCKED) ||
                  (state_q == ST_DISABLED);
  assign sw_run = (state_q == ST_SEARCH) &&
                  (state_d == ST_SEARCH);

  red_pitaya_relock_sweep #(.CNT_W(CNT_W)) u_sweep (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .run_i   (sw_run),
    .clr_i   (sw_clr),
    .step_i  (step_q),
    .amp_i   (amp_q),
    .presc_i (presc_q),
    .off_o   (off)
  );

  always_comb begin
    state_d = state_q;
    rail_d  = rail_q;
    scnt_d  = scnt_q;
    rlc_d   = rlc_q;
    if (!en_q) begin
      state_d = ST_DISABLED;
      rail_d  = '0;
      scnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_DISABLED: begin
          state_d = ST_LOCKED;
          rail_d  = '0;
        end
        ST_LOCKED: begin
          if (railed_i != 2'b00) begin
            rail_d = rail_nx[CNT_W-1:0];
            if (rail_nx >= hold_lim) begin
              state_d = ST_SEARCH;
              rail_d  = '0;
              if (rlc_q != '1)
                rlc_d = rlc_q + {{(RLC_W-1){1'b0}}, 1'b1};
            end
          end else begin
            rail_d = '0;
          end
        end
        ST_SEARCH: begin
          if (lock_hi) begin
            state_d = ST_ACQUIRE;
            scnt_d  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (!lock_hi) begin
            state_d = ST_SEARCH;
          end else if (scnt_nx >= set_lim) begin
            state_d = ST_LOCKED;
            rail_d  = '0;
          end else begin
            scnt_d = scnt_nx[CNT_W-1:0];
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
    if (wr_status)
      rlc_d = '0;
  end

  assign sum = {{2{center_i[13]}}, center_i} +
               {off[14], off};

  always_comb begin
    rdata_d = '0;
    case (addr)
      A_CTRL:    rdata_d[0]         = en_q;
      A_HOLDOFF: rdata_d[CNT_W-1:0] = holdoff_q;
      A_STEP:    rdata_d[13:0]      = step_q;
      A_PRESC:   rdata_d[CNT_W-1:0] = presc_q;
      A_AMP:     rdata_d[13:0]      = amp_q;
      A_THR:     rdata_d[13:0]      = thr_q;
      A_SETTLE:  rdata_d[CNT_W-1:0] = settle_q;
      A_STATUS: begin
        rdata_d[1:0]        = state_q;
        rdata_d[16+:RLC_W]  = rlc_q;
      end
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_DISABLED;
      rail_q  <= '0;
      scnt_q  <= '0;
      rlc_q   <= '0;
      dat_q   <= '0;
      hold_q  <= 1'b0;
      srch_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rail_q  <= rail_d;
      scnt_q  <= scnt_d;
      rlc_q   <= rlc_d;
      if ((state_q == ST_LOCKED) || (state_q == ST_DISABLED))
        dat_q <= pid_dat_i;
      else
        dat_q <= sat14(sum);
      hold_q  <= (state_d == ST_SEARCH);
      srch_q  <= (state_d == ST_SEARCH) ||
                 (state_d == ST_ACQUIRE);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q      <= 1'b0;
      holdoff_q <= CNT_W'(HOLDOFF_RST);
      step_q    <= STEP_RST;
      presc_q   <= '0;
      amp_q     <= AMP_RST;
      thr_q     <= THR_RST;
      settle_q  <= CNT_W'(SETTLE_RST);
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q <= sys_wen | sys_ren;
      if (sys_ren)
        rdata_q <= rdata_d;
      if (sys_wen) begin
        case (addr)
          A_CTRL:    en_q      <= sys_wdata[0];
          A_HOLDOFF: holdoff_q <= sys_wdata[CNT_W-1:0];
          A_STEP:    step_q    <= sys_wdata[13:0];
          A_PRESC:   presc_q   <= sys_wdata[CNT_W-1:0];
          A_AMP:     amp_q     <= sys_wdata[13:0];
          A_THR:     thr_q     <= sys_wdata[13:0];
          A_SETTLE:  settle_q  <= sys_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign dat_o       = dat_q;
  assign pid_hold_o  = hold_q;
  assign searching_o = srch_q;
  assign sys_rdata   = rdata_q;
  assign sys_ack     = ack_q;
  assign sys_err     = 1'b0;

endmodule
